adder_seq_ctrl: RTL and testbench
=================================

Name: adder_seq_ctrl

Overview:
Sequencer that runs multi-precision add/subtract of BYTES*WIDTH-bit operands through a single WIDTH-bit full_adder, one slice per clock, least-significant slice first. The carry is held in a register between slices. Operands are taken on a start pulse; the result is reported with a one-cycle done pulse. It is the control layer that lets the narrow adder datapath serve wide arithmetic.

Parameters:
WIDTH, 8, slice width in bits; must match the full_adder instance.
BYTES, 4, number of slices per operand; must be >= 2.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  request an operation; sampled only when the block is not busy.
sub_i  input  1  0 = A + B + cy_i; 1 = A - B (A + ~B + 1), with cy_i ignored.
cy_i  input  1  carry-in for add.
op_a_i  input  BYTES*WIDTH  operand A.
op_b_i  input  BYTES*WIDTH  operand B.
busy_o  output  1  high while in RUN.
done_o  output  1  one-cycle pulse when the result is valid.
res_o  output  BYTES*WIDTH  result; held until the next accepted start.
cy_o  output  1  carry-out of the MSB slice; for sub, 1 = no borrow.
ovf_o  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_i high at an edge, overrides everything):
  - state = IDLE; res_o, cy_o, ovf_o, done_o, busy_o = 0; slice index = 0; carry reg = 0.
- States: IDLE, RUN, DONE.
- Start acceptance (start_i high at an edge while in IDLE or DONE):
  - latch A; latch B_eff = sub_i ? ~op_b_i : op_b_i.
  - carry reg = sub_i ? 1 : cy_i; idx = 0; res_o cleared to 0; go to RUN.
- RUN:
  - full_adder gets slice idx of latched A and B_eff, plus the carry reg.
  - each edge: write y_o into res_o slice idx; carry reg <= cy_o; idx++.
  - at the edge with idx = BYTES-1: go to DONE, set cy_o = adder carry, compute ovf_o.
- ovf_o rule: ovf = (A_msb == B_eff_msb) && (result_msb != A_msb).
- DONE: done_o = 1 for exactly this one cycle; busy_o = 0.
  - start_i high → accepted, go to RUN (back-to-back allowed).
  - otherwise → go to IDLE.
- Latency: start accepted at edge k → done_o high between edges k+BYTES and k+BYTES+1; throughput is one operation per BYTES+1 cycles.
- start_i while in RUN: ignored; operand inputs are don't-care during RUN.
- res_o, cy_o, ovf_o are stable from DONE until the next accepted start. Partial res_o during RUN is not valid.
- Index counter width = clog2(BYTES); idx never wraps past BYTES-1.
- Reset mid-RUN: abort, return to IDLE with all outputs cleared, no done_o pulse.

Decomposition:
- Shared package: state encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH/BYTES constants.
- One sub-module instance: full_adder (ports a_i, b_i, cy_i, y_o, cy_o) as the slice datapath.
- Slice mux and result register stay in this module.

Test Plan:
All scenarios use BYTES=4, WIDTH=8.
- Add 0x000000FF + 0x00000001, cy_i=0 → res_o 0x00000100, cy_o 0, ovf_o 0; done_o exactly 4 edges after the start edge, 1 cycle wide.
- Add 0xFFFFFFFF + 0x00000000, cy_i=1 → res_o 0x00000000, cy_o 1, ovf_o 0 (carry ripples through every slice).
- Add 0x7FFFFFFF + 0x00000001 → res_o 0x80000000, cy_o 0, ovf_o 1.
- Sub 0x00000005 - 0x00000007 with cy_i=1 (ignored) → res_o 0xFFFFFFFE, cy_o 0, ovf_o 0.
- Sub 0x80000000 - 0x00000001 → res_o 0x7FFFFFFF, cy_o 1, ovf_o 1.
- Control and boundary cases:
  - start_i pulsed mid-RUN with new operands → ignored; first result unchanged.
  - start_i held high in the DONE cycle → second op accepted; second done_o 5 cycles after the first.
  - rst_i asserted at idx=2 → busy_o, done_o, res_o all 0 next cycle and no done_o; the following op completes correctly.

Source files
------------

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and default sizing for the multi-precision add/sub sequencer.
package adder_seq_ctrl_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int BYTES_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/adder_seq_ctrl_full_adder.sv
// WIDTH-bit slice adder with carry in/out; purely combinational, no flow control.
module full_adder
   import adder_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cy_i,
   output logic [WIDTH-1:0] y_o,
   output logic             cy_o
);

   assign {cy_o, y_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cy_i};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Runs BYTES*WIDTH-bit add/sub through one WIDTH-bit adder, LS slice first; done_o BYTES cycles
// after an accepted start. start_i is ignored while busy; back-to-back start accepted in DONE.
module adder_seq_ctrl
   import adder_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int BYTES = BYTES_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   sub_i,
   input  logic                   cy_i,
   input  logic [BYTES*WIDTH-1:0] op_a_i,
   input  logic [BYTES*WIDTH-1:0] op_b_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [BYTES*WIDTH-1:0] res_o,
   output logic                   cy_o,
   output logic                   ovf_o
);

   localparam int N  = BYTES * WIDTH;
   localparam int IW = $clog2(BYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [N-1:0]    res_q, res_d;
   logic            cy_q, cy_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   logic [WIDTH-1:0] fa_a, fa_b, fa_y;
   logic             fa_cy;

   assign fa_a = a_q[idx_q*WIDTH +: WIDTH];
   assign fa_b = b_q[idx_q*WIDTH +: WIDTH];

   full_adder #(.WIDTH(WIDTH)) u_fa (
      .a_i  (fa_a),
      .b_i  (fa_b),
      .cy_i (carry_q),
      .y_o  (fa_y),
      .cy_o (fa_cy)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      res_d   = res_q;
      cy_d    = cy_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               // Subtract is A + ~B + 1; B is stored already inverted.
               a_d     = op_a_i;
               b_d     = sub_i ? ~op_b_i : op_b_i;
               carry_d = sub_i ? 1'b1 : cy_i;
               idx_d   = '0;
               res_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            res_d[idx_q*WIDTH +: WIDTH] = fa_y;
            carry_d = fa_cy;
            if (idx_q == LAST_IDX) begin
               cy_d    = fa_cy;
               ovf_d   = (a_q[N-1] == b_q[N-1]) && (fa_y[WIDTH-1] != a_q[N-1]);
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               idx_d  = idx_q + 1'b1;
               busy_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign res_o  = res_q;
   assign cy_o   = cy_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: whole-word arithmetic model with cycle countdown, plus literal cases.
module tb_adder_seq_ctrl;
   localparam int WIDTH = 8;
   localparam int BYTES = 4;
   localparam int N     = WIDTH * BYTES;

   logic         clk = 1'b0;
   logic         rst, start, sub, cyi;
   logic [N-1:0] opa, opb;
   logic         busy, done, cyo, ovf;
   logic [N-1:0] res;

   adder_seq_ctrl #(.WIDTH(WIDTH), .BYTES(BYTES)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .sub_i   (sub),
      .cy_i    (cyi),
      .op_a_i  (opa),
      .op_b_i  (opb),
      .busy_o  (busy),
      .done_o  (done),
      .res_o   (res),
      .cy_o    (cyo),
      .ovf_o   (ovf)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole-word reference arithmetic.
   task automatic model_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                           input logic c, output logic [N-1:0] r, output logic co,
                           output logic ov);
      logic [N:0]   sum;
      logic [N-1:0] be;
      be  = s ? ~b : b;
      sum = {1'b0, a} + {1'b0, be} + (N+1)'(s ? 1'b1 : c);
      r   = sum[N-1:0];
      co  = sum[N];
      ov  = (a[N-1] == be[N-1]) && (r[N-1] != a[N-1]);
   endtask

   int           m_left = 0;
   logic [N-1:0] m_res = '0, p_res = '0;
   logic         m_cy = 1'b0, m_ovf = 1'b0, m_done = 1'b0;
   logic         p_cy = 1'b0, p_ovf = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0; m_res = '0; m_cy = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1; m_res = p_res; m_cy = p_cy; m_ovf = p_ovf;
            end
         end else if (start) begin
            model_op(opa, opb, sub, cyi, p_res, p_cy, p_ovf);
            m_left = BYTES;
            m_res  = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", N'(busy), N'(m_left > 0));
         chk("done", N'(done), N'(m_done));
         if (m_left == 0) begin
            chk("res", res, m_res);
            chk("cy", N'(cyo), N'(m_cy));
            chk("ovf", N'(ovf), N'(m_ovf));
         end
      end
   end

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input logic c, input logic [N-1:0] er, input logic ec,
                         input logic eo, input string name, input bit glitch);
      int cnt;
      @(negedge clk);
      opa = a; opb = b; sub = s; cyi = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (glitch && cnt == 2) begin
            start = 1'b1; opa = ~a; opb = 32'h1234_5678; sub = ~s;
         end else begin
            start = 1'b0;
         end
      end
      chk({name, " latency"}, N'(cnt), N'(BYTES));
      chk({name, " res"}, res, er);
      chk({name, " cy"}, N'(cyo), N'(ec));
      chk({name, " ovf"}, N'(ovf), N'(eo));
   endtask

   initial begin
      int cnt;
      int seen;
      rst = 1'b1; start = 1'b0; sub = 1'b0; cyi = 1'b0; opa = '0; opb = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("reset busy", N'(busy), '0);
      chk("reset done", N'(done), '0);
      chk("reset res", res, '0);
      chk("reset cy", N'(cyo), '0);
      chk("reset ovf", N'(ovf), '0);
      rst = 1'b0;

      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_ff_1", 1'b0);
      run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "add_ripple", 1'b0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf", 1'b0);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg", 1'b0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf", 1'b0);
      run_op(32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, "glitch_start", 1'b1);

      // Back-to-back: start held in the DONE cycle.
      @(negedge clk);
      opa = 32'h0000_0003; opb = 32'h0000_0004; sub = 1'b0; cyi = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (done !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
      chk("b2b first res", res, 32'h0000_0007);
      opa = 32'h0000_0010; opb = 32'h0000_0020; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 1;
      while (done !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
      chk("b2b spacing", N'(cnt), N'(BYTES + 1));
      chk("b2b second res", res, 32'h0000_0030);

      // Reset while idx = 2.
      @(negedge clk);
      opa = 32'h1111_1111; opb = 32'h2222_2222; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst busy", N'(busy), '0);
      chk("midrst done", N'(done), '0);
      chk("midrst res", res, '0);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin @(negedge clk); if (done === 1'b1) seen++; end
      chk("midrst no done", N'(seen), '0);
      run_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0, 32'h1122_3344, 1'b0, 1'b0, "after_rst", 1'b0);

      // Random traffic against the model, including rare resets.
      repeat (600) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         opa   = $urandom;
         opb   = (($urandom_range(0, 3) == 0) ? ~opa : N'($urandom));
         sub   = 1'($urandom_range(0, 1));
         cyi   = 1'($urandom_range(0, 1));
         rst   = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (8) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
